dmem_arbiter: RTL
=================

# dmem_arbiter

Round-robin arbiter that shares the single-port synchronous data memory (32 x 32-bit, write when WE=1, else registered read) between N requesters, e.g. the CPU load/store unit and a DMA/debug port. Each cycle it grants at most one request, drives the memory address, data and WE lines, and returns read data one cycle later on a per-requester valid strobe. A lock option supports atomic read-modify-write sequences, and addresses outside the memory depth are range-checked.

## Interface

Parameters:
- `N_REQ`, default 2: number of requesters (2..4).
- `DATA_W`, default 32: data width.
- `ADDR_W`, default 32: address width (word address).
- `DEPTH`, default 32: number of memory words; valid addresses are 0..DEPTH-1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req`  in  N_REQ: request, held until granted.
- `req_we`  in  N_REQ: 1 = write, 0 = read.
- `req_lock`  in  N_REQ: keep ownership after this grant.
- `req_addr`  in  N_REQ*ADDR_W: flattened word addresses; slice i belongs to requester i.
- `req_wdata`  in  N_REQ*DATA_W: flattened write data.
- `gnt`  out  N_REQ: one-hot grant, combinational, same cycle as the accepted request.
- `rvalid`  out  N_REQ: read data valid for requester i (registered).
- `rdata`  out  DATA_W: read data, meaningful only while any `rvalid` bit is high.
- `err`  out  N_REQ: out-of-range access pulse (registered).
- `mem_a`  out  ADDR_W: memory address.
- `mem_d`  out  DATA_W: memory write data.
- `mem_we`  out  1: memory write enable.
- `mem_q`  in  DATA_W: memory registered read data.

## Operation

- State `ARB`: the winner is the first requester with `req`=1, scanning from pointer `ptr` upward with wrap-around. After a grant to requester i, `ptr` becomes (i+1) mod N_REQ.
- State `LOCKED(owner)` is entered when the granted request has `req_lock`=1.
  - While in `LOCKED`, only `owner` can be granted. Other requests stall with `gnt`=0.
  - The block returns to `ARB` after an owner grant with `req_lock`=0, i.e. the last access of the atomic sequence.
  - `ptr` is not updated on grants made in `LOCKED`. On the exit grant, `ptr` becomes owner+1.
- Granted cycle, in range (addr < DEPTH): `mem_a`=addr, `mem_d`=wdata, `mem_we`=req_we.
- Granted cycle, out of range: `mem_we` is forced to 0, `mem_a`=0, and `err[i]` pulses in the next cycle. For a read, `rvalid[i]` also pulses with `rdata`=0.
- No grant: `mem_we`=0 and `mem_a`/`mem_d` hold their last driven values. The idle memory read is harmless.
- Writes produce no `rvalid`. `gnt` is the write completion.
- Response pipeline: a one-stage register records {valid, requester index, out-of-range flag} of a granted read.
- Reset values: `ptr`=0, state `ARB`, `rvalid`=0, `err`=0, `mem_we`=0, `mem_a`=0, `mem_d`=0.
- Reset mid-operation: any pending `rvalid` is dropped and a held lock is released.
- Requester protocol violation: dropping `req` before `gnt` is legal; the request is simply withdrawn.

## Timing

- Grant latency: 0 cycles. `gnt` is asserted in the same cycle as `req` if that requester wins.
- Read latency: `rvalid`/`rdata` appear in cycle T+1 for a read granted in cycle T. `rdata` = `mem_q` in that cycle.
- Write commits at the rising edge that ends the grant cycle.
- Throughput: one access per cycle. Back-to-back grants are allowed, with a new grant in T+1 alongside the T response.
- `rvalid` is one-hot or zero and lasts exactly one cycle. It is never stalled; requesters must accept it.

## Structure

- Package `dmem_arb_pkg`: state enum (`ARB`, `LOCKED`), `IDX_W` = clog2(N_REQ), and the response-register struct {valid, idx, oor}.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are the request vector, pointer and mask; outputs are the one-hot grant and the winner index.
- The top level holds the state register, `ptr`, owner, the response register and the memory-side muxing.

## Test plan

- Single read: req[0], addr 5, memory preloaded with mem[i]=i. Required: gnt[0] in cycle T; rvalid[0]=1 and rdata=5 in T+1.
- Contention: req[0] and req[1] both held high from reset, with reads at addr 3 and 7. Required: grants go 0, 1, 0, 1 on consecutive cycles, and rdata alternates 3, 7.
- Write then read: requester 1 writes 32'hDEADBEEF to addr 9, then reads addr 9. Required: mem_we=1 only in the write cycle; rdata=32'hDEADBEEF one cycle after the read grant.
- Lock: requester 0 reads addr 4 with lock=1 while req[1] is held, then writes 5 with lock=0. Required: gnt[1]=0 throughout; mem[4]=5 afterward; requester 1 is granted in the next cycle.
- Out of range: requester 1 reads addr 40 and writes addr 32. Required: mem_we=0 in both grant cycles; err[1] pulses one cycle after each grant; the read returns rvalid[1]=1 with rdata=0.
- Reset mid-operation: assert rst_n=0 in the cycle after a read grant. Required: rvalid=0, the lock is cleared, and after release the first grant goes to requester 0 (ptr=0).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, index width and
// the layout of the one-stage read-response register.
package dmem_arb_pkg;

  // Index width covers the largest supported requester count (4).
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             oor;
  } resp_t;

  // Round-robin successor of requester i among n requesters.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i, input int n);
    return (int'(i) == (n - 1)) ? IDX_W'(0) : (i + IDX_W'(1));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first masked request found
// scanning upward from ptr with wrap-around.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] req_m_s;
  logic [N_REQ-1:0] rot_s;
  logic [IDX_W-1:0] idx_s;

  // Rotate the masked requests so that bit 0 corresponds to requester ptr.
  always_comb begin
    req_m_s = req & mask;
    rot_s   = (req_m_s >> ptr) | (req_m_s << (N_REQ - int'(ptr)));
  end

  // Lowest rotated position wins; scan downward so the lowest overwrites last.
  always_comb begin
    idx_s = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        idx_s = IDX_W'(((int'(ptr) + k) >= N_REQ) ? (int'(ptr) + k - N_REQ) : (int'(ptr) + k));
      end else begin
        idx_s = idx_s;
      end
    end
  end

  // One-hot grant decode of the winner index.
  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      gnt[j] = (|req_m_s) && (idx_s == IDX_W'(j));
    end
  end

  assign idx = idx_s;
  assign any = |req_m_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous data memory among
// N_REQ requesters, with lock support for atomic sequences and range checking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        err,
  output logic [ADDR_W-1:0]       mem_a,
  output logic [DATA_W-1:0]       mem_d,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_q
);

  arb_state_e       state_r, state_n;
  logic [IDX_W-1:0] ptr_r, ptr_n;
  logic [IDX_W-1:0] owner_r, owner_n;
  resp_t            resp_r, resp_n;
  logic [N_REQ-1:0] err_r;
  logic [ADDR_W-1:0] mem_a_r;
  logic [DATA_W-1:0] mem_d_r;

  logic [N_REQ-1:0]  mask_s;
  logic [N_REQ-1:0]  gnt_s;
  logic [IDX_W-1:0]  win_s;
  logic              any_gnt_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_we_s;
  logic              sel_lock_s;
  logic              oor_s;

  // While locked only the owner may win; otherwise everyone competes.
  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      mask_s[j] = (state_r == ARB) || (owner_r == IDX_W'(j));
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req),
    .ptr  (ptr_r),
    .mask (mask_s),
    .gnt  (gnt_s),
    .idx  (win_s),
    .any  (any_gnt_s)
  );

  // AND-OR select of the granted requester's fields (grant is one-hot).
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_we_s    = 1'b0;
    sel_lock_s  = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      sel_addr_s  = sel_addr_s  | ({ADDR_W{gnt_s[j]}} & req_addr[j*ADDR_W +: ADDR_W]);
      sel_wdata_s = sel_wdata_s | ({DATA_W{gnt_s[j]}} & req_wdata[j*DATA_W +: DATA_W]);
      sel_we_s    = sel_we_s    | (gnt_s[j] & req_we[j]);
      sel_lock_s  = sel_lock_s  | (gnt_s[j] & req_lock[j]);
    end
    oor_s = any_gnt_s && (sel_addr_s >= ADDR_W'(DEPTH));
  end

  // Memory-side drive: granted access, or hold the last driven address/data.
  always_comb begin
    if (any_gnt_s) begin
      mem_a  = oor_s ? '0 : sel_addr_s;
      mem_d  = sel_wdata_s;
      mem_we = sel_we_s & ~oor_s;
    end else begin
      mem_a  = mem_a_r;
      mem_d  = mem_d_r;
      mem_we = 1'b0;
    end
  end

  // Next state, pointer and owner; ptr only advances on grants made in ARB.
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    owner_n = owner_r;
    case (state_r)
      ARB: begin
        if (any_gnt_s) begin
          ptr_n   = wrap_inc(win_s, N_REQ);
          state_n = sel_lock_s ? LOCKED : ARB;
          owner_n = sel_lock_s ? win_s : owner_r;
        end else begin
          state_n = ARB;
        end
      end
      LOCKED: begin
        if (any_gnt_s && !sel_lock_s) begin
          state_n = ARB;
          ptr_n   = wrap_inc(owner_r, N_REQ);
        end else begin
          state_n = LOCKED;
        end
      end
      default: begin
        state_n = ARB;
      end
    endcase
    resp_n.valid = any_gnt_s & ~sel_we_s;
    resp_n.idx   = win_s;
    resp_n.oor   = oor_s;
  end

  // Arbitration state and response pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
      ptr_r   <= '0;
      owner_r <= '0;
      resp_r  <= '0;
      err_r   <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      resp_r  <= resp_n;
      err_r   <= oor_s ? gnt_s : '0;
    end
  end

  // Remember the last driven memory address/data for idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a_r <= '0;
      mem_d_r <= '0;
    end else if (any_gnt_s) begin
      mem_a_r <= mem_a;
      mem_d_r <= mem_d;
    end
  end

  // Response decode straight from the response register.
  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      rvalid[j] = resp_r.valid && (resp_r.idx == IDX_W'(j));
    end
    rdata = (resp_r.valid && !resp_r.oor) ? mem_q : '0;
  end

  assign gnt = gnt_s;
  assign err = err_r;

endmodule
